// File: rtl/clock_time_counter.sv
// clock_time_counter: BCD hh:mm:ss timekeeping core.
// Advances once per TICK_DIV accepted Tick pulses and accepts validated
// time-set loads. All outputs are registered.
// Build option: define CLOCK_12H_EN for 12-hour mode (01..12 with PM flag);
// the default build is 24-hour mode (00..23, PM tied low).
module clock_time_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Tick,
  input  logic       Load,
  input  logic [7:0] Load_Hours,
  input  logic [7:0] Load_Minutes,
  input  logic [7:0] Load_Seconds,
  input  logic       Load_PM,
  output logic [7:0] Hours,
  output logic [7:0] Minutes,
  output logic [7:0] Seconds,
  output logic       PM,
  output logic       Minute_Carry,
  output logic       Day_Carry,
  output logic       Load_Error
);

  if (TICK_DIV < 1 || TICK_DIV > 1023) begin : g_bad_tick_div
    $error("clock_time_counter: TICK_DIV must be in 1..1023");
  end

  localparam logic [9:0] DIV_LAST = 10'(TICK_DIV - 1);

`ifdef CLOCK_12H_EN
  localparam logic [7:0] HOURS_RST = 8'h12;
`else
  localparam logic [7:0] HOURS_RST = 8'h00;
`endif

  logic [9:0] div_cnt_q, div_cnt_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hr_q, hr_d;
  logic       min_carry_q, min_carry_d;
  logic       day_carry_q, day_carry_d;
  logic       load_err_q, load_err_d;
  logic       advance;
  logic       load_ok;

`ifdef CLOCK_12H_EN
  logic pm_q, pm_d;
`else
  logic unused_load_pm;
  assign unused_load_pm = Load_PM;
`endif

  // Increment a BCD value that counts 00..59.
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Plain two-digit BCD increment; hour wrap is handled by the caller.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Range-check a requested load; every digit must also be BCD.
  function automatic logic load_valid(input logic [7:0] h, input logic [7:0] m,
                                      input logic [7:0] s);
    logic ok;
    ok = (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9) &&
         (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9) && (h[3:0] <= 4'd9);
`ifdef CLOCK_12H_EN
    ok = ok && (((h[7:4] == 4'd0) && (h[3:0] != 4'd0)) ||
                ((h[7:4] == 4'd1) && (h[3:0] <= 4'd2)));
`else
    ok = ok && ((h[7:4] <= 4'd1) || ((h[7:4] == 4'd2) && (h[3:0] <= 4'd3)));
`endif
    return ok;
  endfunction

  assign advance = Tick && (div_cnt_q == DIV_LAST);
  assign load_ok = load_valid(Load_Hours, Load_Minutes, Load_Seconds);

  // Next-state: a load request (valid or not) takes priority over any tick.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    min_carry_d = 1'b0;
    day_carry_d = 1'b0;
    load_err_d  = 1'b0;
`ifdef CLOCK_12H_EN
    pm_d        = pm_q;
`endif
    if (Load) begin
      if (load_ok) begin
        sec_d     = Load_Seconds;
        min_d     = Load_Minutes;
        hr_d      = Load_Hours;
        div_cnt_d = '0;
`ifdef CLOCK_12H_EN
        pm_d      = Load_PM;
`endif
      end else begin
        load_err_d = 1'b1;
      end
    end else if (Tick) begin
      if (advance) begin
        div_cnt_d = '0;
        sec_d     = bcd60_inc(sec_q);
        if (sec_q == 8'h59) begin
          min_carry_d = 1'b1;
          min_d       = bcd60_inc(min_q);
          if (min_q == 8'h59) begin
`ifdef CLOCK_12H_EN
            if (hr_q == 8'h12) begin
              hr_d = 8'h01;
            end else if (hr_q == 8'h11) begin
              hr_d        = 8'h12;
              pm_d        = ~pm_q;
              day_carry_d = pm_q;
            end else begin
              hr_d = bcd_inc(hr_q);
            end
`else
            if (hr_q == 8'h23) begin
              hr_d        = 8'h00;
              day_carry_d = 1'b1;
            end else begin
              hr_d = bcd_inc(hr_q);
            end
`endif
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + 10'd1;
      end
    end
  end

  // State and pulse registers; reset forces midnight with no pulses.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_q   <= '0;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hr_q        <= HOURS_RST;
      min_carry_q <= 1'b0;
      day_carry_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      min_carry_q <= min_carry_d;
      day_carry_q <= day_carry_d;
      load_err_q  <= load_err_d;
    end
  end

`ifdef CLOCK_12H_EN
  // PM flag register, starts at AM.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) pm_q <= 1'b0;
    else          pm_q <= pm_d;
  end
  assign PM = pm_q;
`else
  assign PM = 1'b0;
`endif

  assign Hours        = hr_q;
  assign Minutes      = min_q;
  assign Seconds      = sec_q;
  assign Minute_Carry = min_carry_q;
  assign Day_Carry    = day_carry_q;
  assign Load_Error   = load_err_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter: instance a uses TICK_DIV=1,
// instance b uses TICK_DIV=4; both share the same stimulus.
module tb_clock_time_counter;

`ifdef CLOCK_12H_EN
  localparam logic [7:0] RST_H = 8'h12;
`else
  localparam logic [7:0] RST_H = 8'h00;
`endif

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Tick = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] Load_Hours = 8'h00;
  logic [7:0] Load_Minutes = 8'h00;
  logic [7:0] Load_Seconds = 8'h00;
  logic       Load_PM = 1'b0;

  logic [7:0] a_h, a_m, a_s, b_h, b_m, b_s;
  logic       a_pm, a_mc, a_dc, a_le, b_pm, b_mc, b_dc, b_le;

  int n_checks = 0;
  int n_errors = 0;
  int mc_count = 0;

  clock_time_counter #(.TICK_DIV(1)) u_a (
    .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick), .Load(Load),
    .Load_Hours(Load_Hours), .Load_Minutes(Load_Minutes),
    .Load_Seconds(Load_Seconds), .Load_PM(Load_PM),
    .Hours(a_h), .Minutes(a_m), .Seconds(a_s), .PM(a_pm),
    .Minute_Carry(a_mc), .Day_Carry(a_dc), .Load_Error(a_le)
  );

  clock_time_counter #(.TICK_DIV(4)) u_b (
    .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick), .Load(Load),
    .Load_Hours(Load_Hours), .Load_Minutes(Load_Minutes),
    .Load_Seconds(Load_Seconds), .Load_PM(Load_PM),
    .Hours(b_h), .Minutes(b_m), .Seconds(b_s), .PM(b_pm),
    .Minute_Carry(b_mc), .Day_Carry(b_dc), .Load_Error(b_le)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue n back-to-back ticks; returns at a falling edge, counting a's minute pulses.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      Tick = 1'b1;
      @(negedge Clock);
      mc_count += int'(a_mc);
    end
    Tick = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic pm, input logic with_tick);
    Load_Hours = h;
    Load_Minutes = m;
    Load_Seconds = s;
    Load_PM = pm;
    Load = 1'b1;
    Tick = with_tick;
    @(negedge Clock);
    Load = 1'b0;
    Tick = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    chk("rst_time_in_reset", {a_h, a_m, a_s}, {RST_H, 16'h0000});
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rst_time", {a_h, a_m, a_s}, {RST_H, 16'h0000});
    chk("rst_pulses", {a_pm, a_mc, a_dc, a_le}, 4'b0000);
    chk("rst_time_b", {b_h, b_m, b_s}, {RST_H, 16'h0000});

    mc_count = 0;
    tick_n(61);
    chk("t61_time", {a_h, a_m, a_s}, {RST_H, 16'h0101});
    chk("t61_mc_count", mc_count, 1);
    chk("t61_b_sec", b_s, 8'h15);

    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_a", {a_h, a_m, a_s}, {RST_H, 16'h0000});
    chk("async_rst_b", b_s, 8'h00);
    @(negedge Clock);
    Reset_n = 1'b1;

    tick_n(7);
    chk("div4_7tick_b", b_s, 8'h01);
    chk("div4_7tick_a", a_s, 8'h07);

    do_load(8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("load_a", {a_h, a_m, a_s}, 24'h120000);
    chk("load_b", {b_h, b_m, b_s}, 24'h120000);
    chk("load_no_err", a_le, 1'b0);
    tick_n(3);
    chk("div_cleared_3", b_s, 8'h00);
    tick_n(1);
    chk("div_cleared_4", b_s, 8'h01);
    chk("div_cleared_a", a_s, 8'h04);

    do_load(8'h12, 8'h00, 8'h59, 1'b0, 1'b0);
    do_load(8'h10, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("load_tick_a", {a_h, a_m, a_s}, 24'h100000);
    chk("load_tick_pulses", {a_mc, a_dc}, 2'b00);
    chk("load_tick_b", {b_h, b_m, b_s}, 24'h100000);
    tick_n(4);
    chk("load_tick_b4", {b_h, b_m, b_s}, 24'h100001);
    chk("load_tick_a4", {a_h, a_m, a_s}, 24'h100004);

    do_load(8'h12, 8'h34, 8'h5A, 1'b0, 1'b0);
    chk("bad_sec_err", a_le, 1'b1);
    chk("bad_sec_time", {a_h, a_m, a_s}, 24'h100004);
    chk("bad_sec_b_time", {b_h, b_m, b_s}, 24'h100001);
    @(negedge Clock);
    chk("bad_sec_err_drop", a_le, 1'b0);
    tick_n(1);
    chk("bad_sec_resume", {a_h, a_m, a_s}, 24'h100005);
    do_load(8'h10, 8'h60, 8'h00, 1'b0, 1'b0);
    chk("bad_min_err", a_le, 1'b1);

    do_load(8'h09, 8'h59, 8'h59, 1'b0, 1'b0);
    tick_n(1);
    chk("h09_wrap_time", {a_h, a_m, a_s}, 24'h100000);
    chk("h09_wrap_pulses", {a_mc, a_dc}, 2'b10);

`ifdef CLOCK_12H_EN
    do_load(8'h11, 8'h59, 8'h59, 1'b1, 1'b0);
    chk("pm_loaded", a_pm, 1'b1);
    tick_n(1);
    chk("pm_day_time", {a_h, a_m, a_s}, 24'h120000);
    chk("pm_day_flags", {a_pm, a_mc, a_dc}, 3'b011);
    do_load(8'h12, 8'h59, 8'h59, 1'b0, 1'b0);
    tick_n(1);
    chk("h12_wrap_time", {a_h, a_m, a_s}, 24'h010000);
    chk("h12_wrap_flags", {a_pm, a_mc, a_dc}, 3'b010);
    do_load(8'h11, 8'h59, 8'h59, 1'b0, 1'b0);
    tick_n(1);
    chk("am_to_pm_time", {a_h, a_m, a_s}, 24'h120000);
    chk("am_to_pm_flags", {a_pm, a_mc, a_dc}, 3'b110);
    do_load(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("bad_h00_err", a_le, 1'b1);
    do_load(8'h13, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("bad_h13_err", a_le, 1'b1);
    chk("bad_h13_time", {a_h, a_m, a_s}, 24'h120000);
`else
    do_load(8'h23, 8'h59, 8'h58, 1'b1, 1'b0);
    tick_n(1);
    chk("day_pre_time", {a_h, a_m, a_s}, 24'h235959);
    chk("day_pre_pulses", {a_mc, a_dc}, 2'b00);
    tick_n(1);
    chk("day_wrap_time", {a_h, a_m, a_s}, 24'h000000);
    chk("day_wrap_pulses", {a_mc, a_dc}, 2'b11);
    chk("day_wrap_pm", a_pm, 1'b0);
    @(negedge Clock);
    chk("day_pulse_drop", {a_mc, a_dc}, 2'b00);
    chk("day_b_held", {b_h, b_m, b_s}, 24'h235958);
    do_load(8'h24, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("bad_h24_err", a_le, 1'b1);
    chk("bad_h24_time", {a_h, a_m, a_s}, 24'h000000);
    tick_n(1);
    chk("bad_h24_resume", {a_h, a_m, a_s}, 24'h000001);
    chk("bad_h24_b_div", {b_h, b_m, b_s}, 24'h235958);
    tick_n(1);
    chk("bad_h24_b_adv", {b_h, b_m, b_s}, 24'h235959);
    do_load(8'h1A, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("bad_h1A_err", a_le, 1'b1);
    do_load(8'h19, 8'h59, 8'h59, 1'b0, 1'b0);
    tick_n(1);
    chk("h19_wrap_time", {a_h, a_m, a_s}, 24'h200000);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
